// File: rtl/lcd_bcd_seq.sv
// lcd_bcd_seq: multi-digit binary to seven-segment display driver.
// A shift-add-3 (double-dabble) engine converts one input bit per clock
// into D BCD digits, then registers the BCD result, the segment codes and
// the overflow flag in one final LOAD step.
module lcd_bcd_seq #(
    parameter int W        = 14,
    parameter int D        = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [W-1:0]   bin_in,
    output logic           busy,
    output logic           done,
    output logic           overflow,
    output logic [4*D-1:0] bcd_out,
    output logic [7*D-1:0] Segment
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int LIM_W = $clog2(10 ** D);
    localparam int CMP_W = (W > LIM_W) ? W : LIM_W;
    localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(10 ** D - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     bin_q, bin_d;
    logic [4*D-1:0]   scratch_q, scratch_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic [4*D-1:0]   bcd_q, bcd_d;
    logic [7*D-1:0]   seg_q, seg_d;

    logic [4*D-1:0]   adjusted;
    logic [7*D-1:0]   seg_view;

    // Seven-segment code for one BCD digit; bit 6 is segment a, bit 0 is g.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h7E;
            4'd1:    code = 7'h30;
            4'd2:    code = 7'h6D;
            4'd3:    code = 7'h79;
            4'd4:    code = 7'h33;
            4'd5:    code = 7'h5B;
            4'd6:    code = 7'h5F;
            4'd7:    code = 7'h70;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h7B;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Add-3 correction applied to every scratch digit before each shift.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < D; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment view of the finished scratch value, blanking leading zeros above digit 0.
    always_comb begin
        logic       upper_zero;
        logic [3:0] digit;
        seg_view   = '0;
        upper_zero = 1'b1;
        digit      = 4'd0;
        for (int i = D - 1; i >= 0; i--) begin
            digit = scratch_q[4*i +: 4];
            if (BLANK_LZ && upper_zero && (digit == 4'd0) && (i != 0)) begin
                seg_view[7*i +: 7] = 7'h00;
            end else begin
                seg_view[7*i +: 7] = seg_decode(digit);
            end
            if (digit != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Next-state and datapath updates for the IDLE -> SHIFT -> LOAD sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        seg_d      = seg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scratch_d  = '0;
                    ovf_pend_d = (CMP_W'(bin_in) > MAX_VAL);
                    busy_d     = 1'b1;
                    cnt_d      = CNT_W'(W);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adjusted[4*D-2:0], bin_q[W-1]};
                bin_d     = {bin_q[W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                overflow_d = ovf_pend_q;
                if (ovf_pend_q) begin
                    bcd_d = '1;
                    seg_d = {D{7'h01}};
                end else begin
                    bcd_d = scratch_q;
                    seg_d = seg_view;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any conversion in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            seg_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            seg_q      <= seg_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;
    assign Segment  = seg_q;

endmodule

// File: tb/tb_lcd_bcd_seq.sv
// tb_lcd_bcd_seq: randomized and directed checks of lcd_bcd_seq against a
// decimal reference model (division/modulo and power-of-ten comparisons).
module tb_lcd_bcd_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [27:0] Segment;

    logic        busy_nb, done_nb, overflow_nb;
    logic [15:0] bcd_nb;
    logic [27:0] seg_nb;

    logic        start_s;
    logic [6:0]  bin_s;
    logic        busy_s, done_s, overflow_s;
    logic [7:0]  bcd_s;
    logic [13:0] seg_s;

    int total = 0;
    int bad   = 0;

    logic [6:0] segTable [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Free-running clock.
    always #5 Clk = ~Clk;

    lcd_bcd_seq #(.W(14), .D(4), .BLANK_LZ(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .overflow(overflow),
        .bcd_out(bcd_out), .Segment(Segment));

    lcd_bcd_seq #(.W(14), .D(4), .BLANK_LZ(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .start(start), .bin_in(bin_in),
        .busy(busy_nb), .done(done_nb), .overflow(overflow_nb),
        .bcd_out(bcd_nb), .Segment(seg_nb));

    lcd_bcd_seq #(.W(7), .D(2), .BLANK_LZ(1'b1)) dut_s (
        .Clk(Clk), .Reset(Reset), .start(start_s), .bin_in(bin_s),
        .busy(busy_s), .done(done_s), .overflow(overflow_s),
        .bcd_out(bcd_s), .Segment(seg_s));

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [23:0] refBcd(input int value, input int nd);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            if (value > pow10(nd) - 1) r[4*i +: 4] = 4'hF;
            else r[4*i +: 4] = 4'((value / pow10(i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [41:0] refSeg(input int value, input int nd, input bit blank);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            if (value > pow10(nd) - 1) r[7*i +: 7] = 7'h01;
            else if (blank && i > 0 && value < pow10(i)) r[7*i +: 7] = 7'h00;
            else r[7*i +: 7] = segTable[(value / pow10(i)) % 10];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkMain(input int value, input string tag);
        checkOutput({tag, "_bcd"},    64'(bcd_out),  64'(refBcd(value, 4)));
        checkOutput({tag, "_seg"},    64'(Segment),  64'(refSeg(value, 4, 1'b1)));
        checkOutput({tag, "_ovf"},    64'(overflow), 64'(value > 9999));
        checkOutput({tag, "_bcd_nb"}, 64'(bcd_nb),   64'(refBcd(value, 4)));
        checkOutput({tag, "_seg_nb"}, 64'(seg_nb),   64'(refSeg(value, 4, 1'b0)));
    endtask

    // Called just after the accepted start edge; returns at the negedge where done is seen.
    task automatic waitDone(input string tag, input int injectAt);
        int lat;
        int busyCycles;
        lat        = 0;
        busyCycles = 0;
        while (lat < 60) begin
            @(negedge Clk);
            if (done) break;
            if (busy) busyCycles++;
            if (lat == injectAt) begin
                start  = 1'b1;
                bin_in = 14'd456;
            end
            @(posedge Clk);
            #1 start = 1'b0;
            bin_in = 14'($urandom);
            lat++;
        end
        checkOutput({tag, "_done"},     64'(done),       64'd1);
        checkOutput({tag, "_latency"},  64'(lat),        64'd15);
        checkOutput({tag, "_busycyc"},  64'(busyCycles), 64'd15);
        checkOutput({tag, "_busy_end"}, 64'(busy),       64'd0);
    endtask

    task automatic applyStimulus(input int value, input string tag);
        @(negedge Clk);
        start  = 1'b1;
        bin_in = 14'(value);
        @(posedge Clk);
        #1 start = 1'b0;
        bin_in = 14'($urandom);
        waitDone(tag, -1);
        checkMain(value, tag);
        @(negedge Clk);
        checkOutput({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int doneSeen;
        int v;
        Reset   = 1'b1;
        start   = 1'b0;
        bin_in  = '0;
        start_s = 1'b0;
        bin_s   = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_busy",  64'(busy),     64'd0);
        checkOutput("rst_done",  64'(done),     64'd0);
        checkOutput("rst_ovf",   64'(overflow), 64'd0);
        checkOutput("rst_bcd",   64'(bcd_out),  64'd0);
        checkOutput("rst_seg",   64'(Segment),  64'd0);
        checkOutput("rst_seg_s", 64'(seg_s),    64'd0);
        Reset = 1'b0;

        $display("[TB] directed values");
        applyStimulus(42, "v42");
        applyStimulus(9999, "v9999");
        applyStimulus(10000, "v10000");
        applyStimulus(0, "v0");
        applyStimulus(1005, "v1005");
        applyStimulus(16383, "vmax");

        $display("[TB] random values");
        for (int k = 0; k < 20; k++) begin
            if (k % 3 == 0) v = int'($urandom_range(0, 16383));
            else v = int'($urandom_range(0, 9999));
            applyStimulus(v, $sformatf("rnd%0d", k));
        end

        $display("[TB] start while busy, then start on done cycle");
        @(negedge Clk);
        start  = 1'b1;
        bin_in = 14'd123;
        @(posedge Clk);
        #1 start = 1'b0;
        bin_in = 14'($urandom);
        waitDone("busy_ign", 5);
        checkMain(123, "busy_ign");
        start  = 1'b1;
        bin_in = 14'd456;
        @(posedge Clk);
        #1 start = 1'b0;
        bin_in = 14'($urandom);
        waitDone("done_cyc", -1);
        checkMain(456, "done_cyc");

        $display("[TB] reset during conversion");
        @(negedge Clk);
        start  = 1'b1;
        bin_in = 14'd8765;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_busy", 64'(busy),     64'd0);
        checkOutput("midrst_seg",  64'(Segment),  64'd0);
        checkOutput("midrst_bcd",  64'(bcd_out),  64'd0);
        checkOutput("midrst_ovf",  64'(overflow), 64'd0);
        Reset    = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (done) doneSeen++;
        end
        checkOutput("midrst_nodone", 64'(doneSeen), 64'd0);
        applyStimulus(31, "after_rst");

        $display("[TB] sweep W=7 D=2");
        for (int s = 0; s < 128; s++) begin
            @(negedge Clk);
            start_s = 1'b1;
            bin_s   = 7'(s);
            @(posedge Clk);
            #1 start_s = 1'b0;
            bin_s = 7'($urandom);
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (!done_s && n < 40);
            checkOutput($sformatf("sw%0d_lat", s), 64'(n),          64'd9);
            checkOutput($sformatf("sw%0d_bcd", s), 64'(bcd_s),      64'(refBcd(s, 2)));
            checkOutput($sformatf("sw%0d_seg", s), 64'(seg_s),      64'(refSeg(s, 2, 1'b1)));
            checkOutput($sformatf("sw%0d_ovf", s), 64'(overflow_s), 64'(s > 99));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bcd_seq.md
Name: lcd_bcd_seq

Overview:
- Multi-digit binary-to-seven-segment display driver; parametrised successor to the two-digit combinational display decoder.
- Converts a W-bit unsigned binary value to D BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. This replaces the divide/modulo arithmetic.
- Drives D seven-segment digit codes, with optional leading-zero blanking and overflow indication.
- Sits between the counter/timer datapath and the display outputs; uses a start/busy/done handshake.

Parameters:
- W, 14, binary input width in bits (legal range 4..20).
- D, 4, number of decimal digits and display positions (legal range 2..6).
- BLANK_LZ, 1, when 1 blank leading-zero digits; when 0 show all digits.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  W  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high from the accepted start edge until the done edge.
- done  output  1  one-cycle pulse when results update.
- overflow  output  1  registered; 1 if the last captured bin_in > 10^D-1.
- bcd_out  output  4*D  registered BCD result; digit i is at [4i+3:4i], digit 0 is the LSD.
- Segment  output  7*D  registered segment codes; digit i is at [7i+6:7i]. Bit 6 = a … bit 0 = g, active high.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high. Reset has priority over every other action on the same edge.
- Reset values:
  - busy = 0, done = 0, overflow = 0.
  - bcd_out = 0.
  - Segment = all 7'h00 (blank).
  - FSM in IDLE, shift counter = 0.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: on an edge with start = 1, capture bin_in into the shift register and clear the BCD scratch register. Also capture ovf_pending = (bin_in > 10^D-1). Set busy = 1, load counter = W, go to SHIFT.
  - SHIFT: each edge, first add 3 to every scratch digit that is >= 5, then shift {scratch, binary} left by 1. Decrement the counter. When the counter reaches 1 on this edge (the W-th shift), go to LOAD.
  - LOAD: on one edge, register bcd_out, Segment and overflow from the scratch result. Set done = 1 and busy = 0, then return to IDLE.
  - done stays high for exactly one cycle.
- Latency: if start is sampled at edge t0, done is high, with new outputs valid, in the cycle after edge t0+W+1. Default latency is 15 edges.
- start while busy = 1 (SHIFT or LOAD) is ignored. bin_in changes after capture have no effect.
- A start on the cycle done is high is accepted, because the FSM is back in IDLE.
- Outputs hold their last values between conversions.
- Digit segment map (value: code):
  - 0: 7E, 1: 30, 2: 6D, 3: 79, 4: 33
  - 5: 5B, 6: 5F, 7: 70, 8: 7F, 9: 7B
  - Any other value: 00.
- Leading-zero blanking (BLANK_LZ = 1): digit i (i >= 1) shows 7'h00 if it and every digit above it are zero. Digit 0 is never blanked, so a value of 0 displays "0". bcd_out is never blanked.
- Overflow (captured value > 10^D-1): overflow = 1, bcd_out = all 4'hF, and every Segment digit = 7'h01 (dash). A non-overflow conversion clears overflow to 0.
- Reset mid-conversion: return to IDLE on that edge. All outputs return to their reset values and no done pulse occurs.
- Arithmetic: the scratch register is 4*D bits. The 10^D-1 comparison is done at width max(W, ceil(log2(10^D))) with no truncation.

Test Plan:
- Reset, then start with bin_in = 42 (W = 14, D = 4, BLANK_LZ = 1) → done pulses exactly 15 edges after start, busy is high for those 15 cycles, bcd_out = 16'h0042, Segment digits [3..0] = 00, 00, 33, 6D, overflow = 0.
- bin_in = 9999 → bcd_out = 16'h9999, all digits = 7B, overflow = 0. Then bin_in = 10000 → overflow = 1, bcd_out = 16'hFFFF, all digits = 01.
- bin_in = 0 with BLANK_LZ = 1 → digits = 00, 00, 00, 7E. Same input with BLANK_LZ = 0 → all digits = 7E. bin_in = 1005 → digits = 30, 7E, 7E, 5B (no internal blanking).
- start with 123, then pulse start with 456 on cycle 5 while busy → the second start is ignored. The single done shows 16'h0123. A start asserted on the done cycle with 456 is accepted and yields 16'h0456 15 edges later.
- Reset asserted 7 cycles into a conversion of 8765 → on the next edge busy = 0, Segment all 00, bcd_out = 0, and no done pulse follows. A new start of 31 completes normally with digits 00, 00, 79, 30.
- Sweep: with W = 7 and D = 2, every value 0..127 compared against a reference model of bin % 10 and bin / 10. Values 100..127 must flag overflow.
